cmd_frame_parser: RTL and testbench
===================================

CMD_FRAME_PARSER -- requirements
Module: cmd_frame_parser

Interface
REQ-001 SHALL have parameter DEF_I2C_ADDR, default 7'h50, I2C-master target used when the frame supplies address 0x00.
REQ-002 SHALL have parameter MAX_LEN, default 16, maximum payload bytes forwarded per frame (range 1..31).
REQ-003 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port rx_data, input, 8, byte received by the upstream I2C slave.
REQ-006 SHALL have port rx_valid, input, 1, one-cycle strobe qualifying rx_data.
REQ-007 SHALL have port frame_end, input, 1, one-cycle strobe on I2C STOP or repeated START.
REQ-008 SHALL have ports spi_data, output, 8, and spi_valid, output, 1, payload toward the SPI-master FIFO.
REQ-009 SHALL have port spi_ready, input, 1, which is the SPI FIFO not-full signal.
REQ-010 SHALL have ports i2c_data, output, 8; i2c_addr, output, 7; and i2c_valid, output, 1, payload toward the I2C-master FIFO.
REQ-011 SHALL have port i2c_ready, input, 1, which is the I2C FIFO not-full signal.
REQ-012 SHALL have port status, output, 8: bit7 err_ovf, bit6 err_cmd, bit5 err_len, bits4:0 byte count of the last completed frame.
REQ-013 SHALL have ports stat_tx_data, output, 8, and stat_tx_valid, output, 1, reply toward the I2C slave transmit path.
REQ-014 SHALL have port clr_err, input, 1, one-cycle pulse that clears the sticky error bits.

Function
REQ-015 SHALL implement states IDLE, GET_ADDR, FWD_SPI, FWD_I2C and DISCARD.
REQ-016 In IDLE, the first rx byte is the command:
- 0x01 -> FWD_SPI.
- 0x02 -> GET_ADDR.
- any other value -> set err_cmd and go to DISCARD.
REQ-017 In GET_ADDR, the next byte's bits6:0 SHALL be latched as the target address and the state SHALL go to FWD_I2C; a latched value of 0x00 SHALL be replaced by DEF_I2C_ADDR.
REQ-018 In FWD_SPI or FWD_I2C, each rx byte SHALL be loaded into that path's one-entry output register and SHALL assert valid on the next cycle.
REQ-019 A path's valid SHALL hold with data stable until the cycle its ready is high; the handoff occurs on valid && ready.
REQ-020 When an rx byte arrives while the target output register is still valid and ready is low, the byte SHALL be dropped, err_ovf SHALL be set, and the state SHALL be unchanged.
REQ-021 A byte arriving in the same cycle the held entry hands off SHALL be accepted without loss.
REQ-022 The payload counter SHALL count accepted payload bytes and saturate at 31.
REQ-023 Once MAX_LEN payload bytes have been forwarded, further bytes SHALL set err_len and the state SHALL go to DISCARD.
REQ-024 In DISCARD, rx bytes SHALL be ignored.
REQ-025 frame_end SHALL, from any state, copy the payload count into status[4:0], clear the counter and return to IDLE.
REQ-026 Pending output entries SHALL NOT be cancelled by frame_end.
REQ-027 When rx_valid and frame_end coincide, the byte SHALL be processed first and then frame_end applied; a command byte arriving with frame_end is therefore decoded, but the state still ends in IDLE.
REQ-028 i2c_addr SHALL be latched per frame and stay stable while i2c_valid is high.
REQ-029 Sticky errors SHALL be set only by their events and cleared by clr_err.
REQ-030 A set event and clr_err in the same cycle SHALL leave the bit set.
REQ-031 Latency from rx_valid to spi_valid or i2c_valid SHALL be exactly 1 cycle when the output register is empty.

Reset
REQ-032 While rst is high at a clock edge:
- state SHALL be IDLE;
- counter, status, all data outputs and i2c_addr SHALL be 0;
- spi_valid, i2c_valid and stat_tx_valid SHALL be 0.
REQ-033 A reset asserted mid-frame SHALL discard held entries, and the first byte after reset release SHALL be decoded as a command.

Configuration
REQ-034 Macro CMD_STATUS_EN SHALL control the status-read command 0x03.
- Defined: command 0x03 in IDLE loads stat_tx_data with status and pulses stat_tx_valid for 1 cycle on the next cycle, then the state goes to DISCARD. The read also clears the sticky errors unless a new error event occurs in the same cycle.
- Undefined: stat_tx_data and stat_tx_valid SHALL be held at 0, and 0x03 SHALL be treated as an unknown command.

Verification
REQ-035 Stimulus: bytes 0x01,0xA5,0x3C then frame_end, spi_ready=1 -> spi_valid pulses carrying 0xA5 then 0x3C, each 1 cycle after its rx byte; status[4:0]=2.
REQ-036 Stimulus: bytes 0x02,0x00,0x11 then frame_end -> i2c_data=0x11 with i2c_addr=0x50; a second frame using address byte 0x27 -> i2c_addr=0x27.
REQ-037 Stimulus: spi_ready=0, frame 0x01,0x10,0x20 -> 0x10 held on spi_data, 0x20 dropped, status[7]=1; after clr_err, status[7]=0.
REQ-038 Stimulus: frame 0x01 followed by 20 payload bytes, spi_ready=1 -> exactly 16 forwarded, status[5]=1, status[4:0]=16.
REQ-039 Stimulus: command 0x7E then 0x55 -> no valid output and status[6]=1; with CMD_STATUS_EN defined, a following 0x03 -> stat_tx_data=0x40 with stat_tx_data[4:0]=last frame count (0 here), then errors clear.
REQ-040 Stimulus: rst pulsed mid-FWD_I2C with i2c_valid high -> i2c_valid=0 after the edge, and next byte 0x01 enters FWD_SPI.

Source files
------------

// File: rtl/cmd_frame_parser.sv
// Command-frame parser: routes I2C-slave bytes to the SPI-master or I2C-master FIFO.
// Optional status-read command 0x03 is enabled by defining CMD_STATUS_EN.
module cmd_frame_parser #(
  parameter logic [6:0]  DEF_I2C_ADDR = 7'h50,
  parameter int unsigned MAX_LEN      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       frame_end,
  output logic [7:0] spi_data,
  output logic       spi_valid,
  input  logic       spi_ready,
  output logic [7:0] i2c_data,
  output logic [6:0] i2c_addr,
  output logic       i2c_valid,
  input  logic       i2c_ready,
  output logic [7:0] status,
  output logic [7:0] stat_tx_data,
  output logic       stat_tx_valid,
  input  logic       clr_err
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_GET_ADDR = 3'd1;
  localparam logic [2:0] ST_FWD_SPI  = 3'd2;
  localparam logic [2:0] ST_FWD_I2C  = 3'd3;
  localparam logic [2:0] ST_DISCARD  = 3'd4;

  localparam logic [7:0] CMD_SPI   = 8'h01;
  localparam logic [7:0] CMD_I2C   = 8'h02;
  localparam logic [4:0] MAX_LEN_C = 5'(MAX_LEN);
  localparam logic [4:0] CNT_SAT   = 5'd31;

  logic [2:0] state_r;
  logic [2:0] state_b_s;
  logic [2:0] state_s;
  logic [4:0] cnt_r;
  logic [4:0] cnt_b_s;
  logic [4:0] cnt_s;
  logic [4:0] last_cnt_r;
  logic [4:0] last_cnt_s;
  logic [6:0] tgt_addr_r;
  logic [6:0] tgt_addr_s;
  logic       err_ovf_r;
  logic       err_cmd_r;
  logic       err_len_r;
  logic       err_ovf_s;
  logic       err_cmd_s;
  logic       err_len_s;
  logic       set_ovf_s;
  logic       set_cmd_s;
  logic       set_len_s;
  logic       clr_s;
  logic       stat_cmd_s;
  logic       stat_rd_s;
  logic       spi_load_s;
  logic       i2c_load_s;
  logic       spi_free_s;
  logic       i2c_free_s;
  logic       in_spi_s;
  logic       path_free_s;
  logic [7:0] status_s;
  logic [7:0] spi_data_r;
  logic       spi_valid_r;
  logic [7:0] i2c_data_r;
  logic [6:0] i2c_addr_r;
  logic       i2c_valid_r;

`ifdef CMD_STATUS_EN
  localparam logic [7:0] CMD_STAT = 8'h03;
  assign stat_cmd_s = (rx_data == CMD_STAT);
`else
  assign stat_cmd_s = 1'b0;
`endif

  // An entry may be loaded when the holding register is empty or hands off this cycle.
  assign spi_free_s  = !spi_valid_r || spi_ready;
  assign i2c_free_s  = !i2c_valid_r || i2c_ready;
  assign in_spi_s    = (state_r == ST_FWD_SPI);
  assign path_free_s = in_spi_s ? spi_free_s : i2c_free_s;
  assign status_s    = {err_ovf_r, err_cmd_r, err_len_r, last_cnt_r};

  // Byte-processing stage: decode commands/addresses and accept or reject payload.
  always_comb begin
    state_b_s  = state_r;
    cnt_b_s    = cnt_r;
    tgt_addr_s = tgt_addr_r;
    spi_load_s = 1'b0;
    i2c_load_s = 1'b0;
    set_ovf_s  = 1'b0;
    set_cmd_s  = 1'b0;
    set_len_s  = 1'b0;
    stat_rd_s  = 1'b0;
    if (rx_valid) begin
      case (state_r)
        ST_IDLE: begin
          if (rx_data == CMD_SPI) begin
            state_b_s = ST_FWD_SPI;
          end else if (rx_data == CMD_I2C) begin
            state_b_s = ST_GET_ADDR;
          end else if (stat_cmd_s) begin
            stat_rd_s = 1'b1;
            state_b_s = ST_DISCARD;
          end else begin
            set_cmd_s = 1'b1;
            state_b_s = ST_DISCARD;
          end
        end
        ST_GET_ADDR: begin
          tgt_addr_s = (rx_data[6:0] == 7'h00) ? DEF_I2C_ADDR : rx_data[6:0];
          state_b_s  = ST_FWD_I2C;
        end
        ST_FWD_SPI, ST_FWD_I2C: begin
          if (cnt_r >= MAX_LEN_C) begin
            set_len_s = 1'b1;
            state_b_s = ST_DISCARD;
          end else if (!path_free_s) begin
            set_ovf_s = 1'b1;
          end else begin
            spi_load_s = in_spi_s;
            i2c_load_s = !in_spi_s;
            cnt_b_s    = (cnt_r == CNT_SAT) ? cnt_r : cnt_r + 5'd1;
          end
        end
        ST_DISCARD: begin
          state_b_s = ST_DISCARD;
        end
        default: begin
          state_b_s = ST_IDLE;
        end
      endcase
    end else begin
      state_b_s = state_r;
    end
  end

  // frame_end is applied after the byte, so a coincident byte is still counted.
  assign state_s    = frame_end ? ST_IDLE : state_b_s;
  assign cnt_s      = frame_end ? 5'd0 : cnt_b_s;
  assign last_cnt_s = frame_end ? cnt_b_s : last_cnt_r;

  // A set event wins over a clear in the same cycle.
  assign clr_s     = clr_err || stat_rd_s;
  assign err_ovf_s = set_ovf_s ? 1'b1 : (clr_s ? 1'b0 : err_ovf_r);
  assign err_cmd_s = set_cmd_s ? 1'b1 : (clr_s ? 1'b0 : err_cmd_r);
  assign err_len_s = set_len_s ? 1'b1 : (clr_s ? 1'b0 : err_len_r);

  // Frame control state, counters and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 5'd0;
      last_cnt_r <= 5'd0;
      tgt_addr_r <= 7'd0;
      err_ovf_r  <= 1'b0;
      err_cmd_r  <= 1'b0;
      err_len_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      last_cnt_r <= last_cnt_s;
      tgt_addr_r <= tgt_addr_s;
      err_ovf_r  <= err_ovf_s;
      err_cmd_r  <= err_cmd_s;
      err_len_r  <= err_len_s;
    end
  end

  // One-entry SPI output register; a pending entry survives frame_end.
  always_ff @(posedge clk) begin
    if (rst) begin
      spi_data_r  <= 8'h00;
      spi_valid_r <= 1'b0;
    end else if (spi_load_s) begin
      spi_data_r  <= rx_data;
      spi_valid_r <= 1'b1;
    end else if (spi_valid_r && spi_ready) begin
      spi_valid_r <= 1'b0;
    end else begin
      spi_valid_r <= spi_valid_r;
    end
  end

  // One-entry I2C output register; address travels with the data so it stays stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      i2c_data_r  <= 8'h00;
      i2c_addr_r  <= 7'h00;
      i2c_valid_r <= 1'b0;
    end else if (i2c_load_s) begin
      i2c_data_r  <= rx_data;
      i2c_addr_r  <= tgt_addr_r;
      i2c_valid_r <= 1'b1;
    end else if (i2c_valid_r && i2c_ready) begin
      i2c_valid_r <= 1'b0;
    end else begin
      i2c_valid_r <= i2c_valid_r;
    end
  end

`ifdef CMD_STATUS_EN
  logic [7:0] stat_data_r;
  logic       stat_valid_r;

  // Status reply: snapshot of status before the read clears the errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_data_r  <= 8'h00;
      stat_valid_r <= 1'b0;
    end else if (stat_rd_s) begin
      stat_data_r  <= status_s;
      stat_valid_r <= 1'b1;
    end else begin
      stat_valid_r <= 1'b0;
    end
  end

  assign stat_tx_data  = stat_data_r;
  assign stat_tx_valid = stat_valid_r;
`else
  assign stat_tx_data  = 8'h00;
  assign stat_tx_valid = 1'b0;
`endif

  assign spi_data  = spi_data_r;
  assign spi_valid = spi_valid_r;
  assign i2c_data  = i2c_data_r;
  assign i2c_addr  = i2c_addr_r;
  assign i2c_valid = i2c_valid_r;
  assign status    = status_s;

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Scoreboard bench for cmd_frame_parser: directed frames plus randomized frames
// checked against a frame-level reference model.
module tb_cmd_frame_parser;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_end;
  logic [7:0] spi_data;
  logic       spi_valid;
  logic       spi_ready;
  logic [7:0] i2c_data;
  logic [6:0] i2c_addr;
  logic       i2c_valid;
  logic       i2c_ready;
  logic [7:0] status;
  logic [7:0] stat_tx_data;
  logic       stat_tx_valid;
  logic       clr_err;

  always #5 clk = ~clk;

  cmd_frame_parser dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .frame_end(frame_end),
    .spi_data(spi_data), .spi_valid(spi_valid), .spi_ready(spi_ready),
    .i2c_data(i2c_data), .i2c_addr(i2c_addr), .i2c_valid(i2c_valid), .i2c_ready(i2c_ready),
    .status(status), .stat_tx_data(stat_tx_data), .stat_tx_valid(stat_tx_valid),
    .clr_err(clr_err)
  );

`ifdef CMD_STATUS_EN
  localparam bit STAT_EN = 1'b1;
`else
  localparam bit STAT_EN = 1'b0;
`endif
  localparam int MAXL = 16;
  localparam int M_IDLE = 0, M_ADDR = 1, M_SPI = 2, M_I2C = 3, M_DISC = 4;

  int n_pass = 0;
  int n_total = 0;
  int spi_hs = 0;
  bit rnd_rdy = 1'b0;

  // reference model state (post-edge view)
  int         m_mode = M_IDLE;
  int         m_cnt = 0;
  int         m_last = 0;
  bit         m_ovf = 1'b0, m_cmd = 1'b0, m_len = 1'b0;
  bit         m_so = 1'b0, m_io = 1'b0, m_stv = 1'b0;
  logic [7:0] m_sd = 8'h00, m_id = 8'h00, m_std = 8'h00;
  logic [6:0] m_ia = 7'h00, m_tgt = 7'h00;
  logic [7:0]  spi_q[$];
  logic [14:0] i2c_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [7:0] m_status();
    return {m_ovf, m_cmd, m_len, 5'(m_last)};
  endfunction

  task automatic model_step();
    bit hs, hi, acc_s, acc_i, s_ovf, s_cmd, s_len, rd, occ, rdy;
    logic [6:0] a;
    if (rst) begin
      m_mode = M_IDLE; m_cnt = 0; m_last = 0;
      m_ovf = 1'b0; m_cmd = 1'b0; m_len = 1'b0;
      m_so = 1'b0; m_io = 1'b0; m_stv = 1'b0;
      m_sd = 8'h00; m_id = 8'h00; m_ia = 7'h00; m_std = 8'h00; m_tgt = 7'h00;
      spi_q.delete();
      i2c_q.delete();
    end else begin
      hs = m_so && spi_ready;
      hi = m_io && i2c_ready;
      acc_s = 1'b0; acc_i = 1'b0; s_ovf = 1'b0; s_cmd = 1'b0; s_len = 1'b0; rd = 1'b0;
      if (rx_valid) begin
        case (m_mode)
          M_IDLE: begin
            if (rx_data == 8'h01) m_mode = M_SPI;
            else if (rx_data == 8'h02) m_mode = M_ADDR;
            else if (STAT_EN && rx_data == 8'h03) begin
              rd = 1'b1; m_std = m_status(); m_mode = M_DISC;
            end else begin
              s_cmd = 1'b1; m_mode = M_DISC;
            end
          end
          M_ADDR: begin
            a = rx_data[6:0];
            m_tgt = (a == 7'h00) ? 7'h50 : a;
            m_mode = M_I2C;
          end
          M_SPI, M_I2C: begin
            occ = (m_mode == M_SPI) ? m_so : m_io;
            rdy = (m_mode == M_SPI) ? spi_ready : i2c_ready;
            if (m_cnt >= MAXL) begin
              s_len = 1'b1; m_mode = M_DISC;
            end else if (occ && !rdy) begin
              s_ovf = 1'b1;
            end else begin
              if (m_mode == M_SPI) begin
                acc_s = 1'b1; spi_q.push_back(rx_data); m_sd = rx_data;
              end else begin
                acc_i = 1'b1; i2c_q.push_back({m_tgt, rx_data}); m_id = rx_data; m_ia = m_tgt;
              end
              m_cnt = (m_cnt < 31) ? m_cnt + 1 : 31;
            end
          end
          default: ;
        endcase
      end
      m_so = (m_so && !hs) || acc_s;
      m_io = (m_io && !hi) || acc_i;
      m_ovf = s_ovf ? 1'b1 : ((clr_err || rd) ? 1'b0 : m_ovf);
      m_cmd = s_cmd ? 1'b1 : ((clr_err || rd) ? 1'b0 : m_cmd);
      m_len = s_len ? 1'b1 : ((clr_err || rd) ? 1'b0 : m_len);
      if (frame_end) begin
        m_last = m_cnt; m_cnt = 0; m_mode = M_IDLE;
      end
      m_stv = rd;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // monitor: compares DUT outputs mid-cycle and pops the scoreboard on each handoff
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("spi_valid", spi_valid, m_so);
      check("i2c_valid", i2c_valid, m_io);
      check("status", status, m_status());
      check("stat_tx_valid", stat_tx_valid, m_stv);
      check("stat_tx_data", stat_tx_data, m_std);
      if (spi_valid) begin
        if (spi_q.size() == 0) begin
          n_total++; $display("FAIL spi_q: unexpected spi entry %0h", spi_data);
        end else begin
          check("spi_data", spi_data, spi_q[0]);
          if (spi_ready) begin void'(spi_q.pop_front()); spi_hs++; end
        end
      end else check("spi_data_idle", spi_data, m_sd);
      if (i2c_valid) begin
        if (i2c_q.size() == 0) begin
          n_total++; $display("FAIL i2c_q: unexpected i2c entry %0h", i2c_data);
        end else begin
          check("i2c_entry", {i2c_addr, i2c_data}, i2c_q[0]);
          if (i2c_ready) void'(i2c_q.pop_front());
        end
      end else check("i2c_entry_idle", {i2c_addr, i2c_data}, {m_ia, m_id});
    end
  end

  task automatic cyc(input bit v, input logic [7:0] d, input bit f);
    rx_valid = v; rx_data = d; frame_end = f;
    if (rnd_rdy) begin
      spi_ready = ($urandom_range(0, 3) != 0);
      i2c_ready = ($urandom_range(0, 3) != 0);
      clr_err = ($urandom_range(0, 29) == 0);
    end
    @(posedge clk);
    #2;
    rx_valid = 1'b0; frame_end = 1'b0;
    if (rnd_rdy) clr_err = 1'b0;
  endtask

  initial begin
    int base;
    int n, k;
    logic [7:0] cmd;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; frame_end = 1'b0;
    spi_ready = 1'b1; i2c_ready = 1'b1; clr_err = 1'b0;
    cyc(0, 8'h00, 0); cyc(0, 8'h00, 0);
    rst = 1'b0;
    check("rst_status", status, 8'h00);
    check("rst_spi_valid", spi_valid, 1'b0);
    check("rst_i2c", {i2c_valid, i2c_addr, i2c_data}, 16'h0000);

    // SPI frame, 1-cycle latency
    cyc(1, 8'h01, 0);
    cyc(1, 8'hA5, 0); check("spi_lat_a5", {spi_valid, spi_data}, 9'h1A5);
    cyc(1, 8'h3C, 0); check("spi_lat_3c", {spi_valid, spi_data}, 9'h13C);
    cyc(0, 8'h00, 1); cyc(0, 8'h00, 0);
    check("status_cnt2", status, 8'h02);

    // I2C frames: default and explicit address
    cyc(1, 8'h02, 0); cyc(1, 8'h00, 0); cyc(1, 8'h11, 0);
    check("i2c_def", {i2c_valid, i2c_addr, i2c_data}, {1'b1, 7'h50, 8'h11});
    cyc(0, 8'h00, 1);
    cyc(1, 8'h02, 0); cyc(1, 8'h27, 0); cyc(1, 8'h66, 0);
    check("i2c_addr27", {i2c_valid, i2c_addr, i2c_data}, {1'b1, 7'h27, 8'h66});
    cyc(0, 8'h00, 1);

    // overflow with SPI FIFO full
    spi_ready = 1'b0;
    cyc(1, 8'h01, 0); cyc(1, 8'h10, 0);
    cyc(1, 8'h20, 0); check("ovf_hold", {spi_valid, spi_data}, 9'h110);
    cyc(0, 8'h00, 1); check("ovf_status", status, 8'h81);
    spi_ready = 1'b1; cyc(0, 8'h00, 0);
    clr_err = 1'b1; cyc(0, 8'h00, 0); clr_err = 1'b0;
    check("ovf_clr", status, 8'h01);

    // length limit
    base = spi_hs;
    cyc(1, 8'h01, 0);
    for (int i = 0; i < 20; i++) cyc(1, 8'(i + 1), 0);
    cyc(0, 8'h00, 1); cyc(0, 8'h00, 0); cyc(0, 8'h00, 0);
    check("len_status", status, 8'h30);
    check("len_fwd", spi_hs - base, 16);

    // unknown command and optional status read
    clr_err = 1'b1; cyc(0, 8'h00, 0); clr_err = 1'b0;
    cyc(1, 8'h7E, 0); cyc(1, 8'h55, 0);
    check("badcmd_novalid", {spi_valid, i2c_valid}, 2'b00);
    cyc(0, 8'h00, 1);
    check("badcmd_status", status, 8'h40);
`ifdef CMD_STATUS_EN
    cyc(1, 8'h03, 0);
    check("stat_rd", {stat_tx_valid, stat_tx_data}, 9'h140);
    check("stat_rd_clr", status, 8'h00);
    cyc(0, 8'h00, 1);
    check("stat_pulse", stat_tx_valid, 1'b0);
`else
    clr_err = 1'b1; cyc(0, 8'h00, 0); clr_err = 1'b0;
    cyc(1, 8'h03, 0);
    check("stat_off", {stat_tx_valid, stat_tx_data}, 9'h000);
    check("stat_off_cmd", status, 8'h40);
    cyc(0, 8'h00, 1);
`endif

    // reset mid-FWD_I2C
    i2c_ready = 1'b0;
    cyc(1, 8'h02, 0); cyc(1, 8'h33, 0); cyc(1, 8'h44, 0);
    check("pre_rst_i2c", i2c_valid, 1'b1);
    rst = 1'b1; cyc(0, 8'h00, 0); rst = 1'b0;
    check("post_rst_i2c", {i2c_valid, i2c_addr, i2c_data}, 16'h0000);
    spi_ready = 1'b1; i2c_ready = 1'b1;
    cyc(1, 8'h01, 0); cyc(1, 8'h99, 0);
    check("post_rst_spi", {spi_valid, spi_data}, 9'h199);
    cyc(0, 8'h00, 1);

    // randomized frames
    rnd_rdy = 1'b1;
    for (int fr = 0; fr < 250; fr++) begin
      k = $urandom_range(0, 9);
      cmd = (k < 4) ? 8'h01 : (k < 8) ? 8'h02 : (k == 8) ? 8'h03 : 8'($urandom_range(0, 255));
      n = $urandom_range(0, 22);
      cyc(1, cmd, 0);
      if (cmd == 8'h02) cyc(1, ($urandom_range(0, 3) == 0) ? 8'h80 : 8'($urandom_range(0, 255)), 0);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) cyc(0, 8'h00, 0);
        if ($urandom_range(0, 150) == 0) begin
          rst = 1'b1; cyc(0, 8'h00, 0); rst = 1'b0;
        end
        cyc(1, 8'($urandom_range(0, 255)), 0);
      end
      if ($urandom_range(0, 3) == 0) cyc(1, 8'($urandom_range(0, 255)), 1);
      else cyc(0, 8'h00, 1);
      repeat ($urandom_range(0, 3)) cyc(0, 8'h00, 0);
    end

    rnd_rdy = 1'b0; spi_ready = 1'b1; i2c_ready = 1'b1; clr_err = 1'b0;
    repeat (5) cyc(0, 8'h00, 0);
    check("drain_spi", spi_q.size(), 0);
    check("drain_i2c", i2c_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
